// File: rtl/oddr_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oddr_burst_ctrl: ODDRE1 SR release sequencing and tristate-framed bursts.  |
// | Define ODDR_BURST_CTRL_B2B_EN to chain bursts directly from POST. Rev 1.0  |
// +----------------------------------------------------------------------------+
module oddr_burst_ctrl #(
    parameter int DW        = 8,
    parameter int BURST_LEN = 4,
    parameter int SR_HOLD   = 4,
    parameter int PRE       = 1,
    parameter int POST      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_d1,
    input  logic [DW-1:0] wr_d2,
    output logic          oddr_sr,
    output logic [DW-1:0] oddr_d1,
    output logic [DW-1:0] oddr_d2,
    output logic          oddr_tri,
    output logic          link_rdy,
    output logic          busy,
    output logic          underrun
);

    localparam int C_SETTLE = 3;
    localparam int C_M0     = (SR_HOLD > C_SETTLE) ? SR_HOLD : C_SETTLE;
    localparam int C_M1     = (BURST_LEN > C_M0) ? BURST_LEN : C_M0;
    localparam int C_M2     = (PRE > C_M1) ? PRE : C_M1;
    localparam int C_MAX    = (POST > C_M2) ? POST : C_M2;
    localparam int C_CNT_W  = $clog2(C_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_HOLD_LAST   = C_CNT_W'(SR_HOLD - 1);
    localparam logic [C_CNT_W-1:0] C_SETTLE_LAST = C_CNT_W'(C_SETTLE - 1);
    localparam logic [C_CNT_W-1:0] C_PRE_LAST    = C_CNT_W'(PRE - 1);
    localparam logic [C_CNT_W-1:0] C_BURST_LAST  = C_CNT_W'(BURST_LEN - 1);
    localparam logic [C_CNT_W-1:0] C_POST_LAST   = C_CNT_W'(POST - 1);

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_SETTLE = 3'd1,
        S_IDLE   = 3'd2,
        S_PRE    = 3'd3,
        S_BURST  = 3'd4,
        S_POST   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 w_cnt_clr;
    logic                 w_in_burst;
    logic                 w_accept;
    logic                 w_frame;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HOLD:   if (r_cnt == C_HOLD_LAST)   w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == C_SETTLE_LAST) w_state_nxt = S_IDLE;
            S_IDLE:   if (wr_valid)               w_state_nxt = (PRE == 0) ? S_BURST : S_PRE;
            S_PRE:    if (r_cnt == C_PRE_LAST)    w_state_nxt = S_BURST;
            S_BURST:  if (r_cnt == C_BURST_LAST)  w_state_nxt = (POST == 0) ? S_IDLE : S_POST;
            S_POST: begin
                if (r_cnt == C_POST_LAST) begin
`ifdef ODDR_BURST_CTRL_B2B_EN
                    w_state_nxt = wr_valid ? S_BURST : S_IDLE;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default:  w_state_nxt = S_HOLD;
        endcase
        // Dropping enable overrides every transition and parks the ODDRs in reset.
        if (!en) begin
            w_state_nxt = S_HOLD;
        end
    end

    assign w_cnt_clr  = !en || (w_state_nxt != r_state) || (r_state == S_IDLE);
    assign w_in_burst = en && (r_state == S_BURST);
    assign w_accept   = w_in_burst && wr_valid;
    assign w_frame    = en && ((r_state == S_PRE) || (r_state == S_BURST) || (r_state == S_POST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_HOLD;
            r_cnt    <= '0;
            oddr_sr  <= 1'b1;
            oddr_tri <= 1'b1;
            oddr_d1  <= '0;
            oddr_d2  <= '0;
            wr_ready <= 1'b0;
            link_rdy <= 1'b0;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_clr ? '0 : r_cnt + C_CNT_W'(1);
            oddr_sr  <= (w_state_nxt == S_HOLD);
            // Tristate and data trail the state by one cycle to line up with the ODDR launch.
            oddr_tri <= !w_frame;
            oddr_d1  <= w_accept ? wr_d1 : '0;
            oddr_d2  <= w_accept ? wr_d2 : '0;
            underrun <= w_in_burst && !wr_valid;
            wr_ready <= (w_state_nxt == S_BURST);
            link_rdy <= (w_state_nxt != S_HOLD) && (w_state_nxt != S_SETTLE);
            busy     <= (w_state_nxt == S_PRE) || (w_state_nxt == S_BURST) ||
                        (w_state_nxt == S_POST);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oddr_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_oddr_burst_ctrl: scoreboard bench for oddr_burst_ctrl frames and link.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_oddr_burst_ctrl;

    localparam int DW        = 8;
    localparam int BURST_LEN = 4;
    localparam int SR_HOLD   = 4;
    localparam int PRE       = 1;
    localparam int POST      = 1;
`ifdef ODDR_BURST_CTRL_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          en;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_d1;
    logic [DW-1:0] wr_d2;
    logic          oddr_sr;
    logic [DW-1:0] oddr_d1;
    logic [DW-1:0] oddr_d2;
    logic          oddr_tri;
    logic          link_rdy;
    logic          busy;
    logic          underrun;

    oddr_burst_ctrl #(
        .DW(DW), .BURST_LEN(BURST_LEN), .SR_HOLD(SR_HOLD), .PRE(PRE), .POST(POST)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_d1    (wr_d1),
        .wr_d2    (wr_d2),
        .oddr_sr  (oddr_sr),
        .oddr_d1  (oddr_d1),
        .oddr_d2  (oddr_d2),
        .oddr_tri (oddr_tri),
        .link_rdy (link_rdy),
        .busy     (busy),
        .underrun (underrun)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit sb_en = 1'b1;

    // Expected line activity: words shown while oddr_tri is low, plus per-frame length/underruns.
    logic [2*DW-1:0] exp_words[$];
    int              exp_len[$];
    int              exp_urun[$];
    bit              open_frame = 1'b0;
    int              open_len;
    int              open_urun;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sr"},       oddr_sr,  1);
        check({tag, "_tri"},      oddr_tri, 1);
        check({tag, "_d1"},       oddr_d1,  0);
        check({tag, "_d2"},       oddr_d2,  0);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_link_rdy"}, link_rdy, 0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_underrun"}, underrun, 0);
    endtask

    // Called at the negedge where the link leaves reset/disable; sample i is i cycles later.
    task automatic bringup_check(input string tag);
        for (int i = 0; i <= SR_HOLD + 3; i++) begin
            #1;
            check({tag, "_sr"},       oddr_sr,  (i < SR_HOLD));
            check({tag, "_link_rdy"}, link_rdy, (i >= SR_HOLD + 3));
            @(negedge clk);
        end
    endtask

    task automatic do_burst(input logic [BURST_LEN-1:0] vmask, input bit chain,
                            input bit fixed, output int start_cyc);
        logic [DW-1:0]   a1 [BURST_LEN];
        logic [DW-1:0]   a2 [BURST_LEN];
        logic [2*DW-1:0] w;
        int              guard;
        for (int k = 0; k < BURST_LEN; k++) begin
            a1[k] = fixed ? DW'(32'h11 * (2 * k + 1)) : DW'($urandom);
            a2[k] = fixed ? DW'(32'h11 * (2 * k + 2)) : DW'($urandom);
        end
        if (!open_frame) begin
            open_len  = 0;
            open_urun = 0;
            for (int k = 0; k < PRE; k++) begin
                exp_words.push_back('0);
                open_len++;
            end
        end
        for (int k = 0; k < BURST_LEN; k++) begin
            w = '0;
            if (vmask[k]) w = {a1[k], a2[k]};
            else open_urun++;
            exp_words.push_back(w);
            open_len++;
        end
        for (int k = 0; k < POST; k++) begin
            exp_words.push_back('0);
            open_len++;
        end
        if (chain && B2B && POST > 0) begin
            open_frame = 1'b1;
        end else begin
            exp_len.push_back(open_len);
            exp_urun.push_back(open_urun);
            open_frame = 1'b0;
        end

        wr_valid = 1'b1;
        guard = 0;
        while (!wr_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("burst_start_ready", wr_ready, 1);
        start_cyc = cyc;
        if (!wr_ready) begin
            wr_valid = 1'b0;
            return;
        end
        for (int k = 0; k < BURST_LEN; k++) begin
            wr_valid = vmask[k];
            wr_d1    = vmask[k] ? a1[k] : DW'($urandom);
            wr_d2    = vmask[k] ? a2[k] : DW'($urandom);
            @(negedge clk);
        end
        wr_valid = chain;
        wr_d1    = '0;
        wr_d2    = '0;
        if (!chain) repeat (POST) @(negedge clk);
    endtask

    // Monitor: gathers each tristate-enabled frame and scores it when the line goes high-Z.
    initial begin : monitor
        logic [2*DW-1:0] fr[$];
        logic [2*DW-1:0] ew;
        logic [2*DW-1:0] aw;
        int              ur;
        int              elen;
        int              eur;
        ur = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst || !sb_en) begin
                fr.delete();
                ur = 0;
            end else if (!oddr_tri) begin
                fr.push_back({oddr_d1, oddr_d2});
                if (underrun) ur++;
            end else begin
                check("idle_data", {oddr_d1, oddr_d2}, 0);
                check("idle_underrun", underrun, 0);
                if (fr.size() > 0) begin
                    n_checks++;
                    if (exp_len.size() == 0) begin
                        n_errors++;
                        $display("FAIL frame_unexpected: got %0d-word frame, expected none",
                                 fr.size());
                    end else begin
                        elen = exp_len.pop_front();
                        eur  = exp_urun.pop_front();
                        check("frame_len", fr.size(), elen);
                        check("frame_underruns", ur, eur);
                        for (int i = 0; i < elen; i++) begin
                            ew = '1;
                            aw = '1;
                            if (exp_words.size() > 0) ew = exp_words.pop_front();
                            if (i < fr.size()) aw = fr[i];
                            check($sformatf("frame_word[%0d]", i), aw, ew);
                        end
                    end
                    fr.delete();
                    ur = 0;
                end
            end
        end
    end

    initial begin : stimulus
        int s1;
        int s2;
        int guard;
        logic [BURST_LEN-1:0] m;
        bit ch;

        rst      = 1'b1;
        en       = 1'b1;
        wr_valid = 1'b0;
        wr_d1    = '0;
        wr_d2    = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        bringup_check("bringup");

        // Fixed 0x11/0x22 .. 0x77/0x88 burst, valid held throughout
        do_burst('1, 1'b0, 1'b1, s1);
        repeat (2) @(negedge clk);

        // Second beat missing: one underrun, zero data in its slot, same frame length
        m = '1;
        m[1] = 1'b0;
        do_burst(m, 1'b0, 1'b1, s1);
        repeat (2) @(negedge clk);

        // Two requests back to back
        do_burst('1, 1'b1, 1'b1, s1);
        do_burst('1, 1'b0, 1'b1, s2);
        check("b2b_gap", s2 - s1,
              BURST_LEN + ((B2B && POST > 0) ? POST : POST + 1 + PRE));
        repeat (2) @(negedge clk);

        for (int n = 0; n < 24; n++) begin
            m = '1;
            if ($urandom_range(0, 2) == 0) m = BURST_LEN'($urandom);
            ch = (n < 23) && ($urandom_range(0, 2) == 0);
            do_burst(m, ch, 1'b0, s1);
            if (!ch) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        // Enable dropped in the middle of a burst
        sb_en    = 1'b0;
        wr_valid = 1'b1;
        wr_d1    = 8'h3C;
        wr_d2    = 8'hC3;
        guard = 0;
        while (!wr_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("abort_burst_started", wr_ready, 1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        #1;
        check("abort_sr",       oddr_sr,  1);
        check("abort_tri",      oddr_tri, 1);
        check("abort_wr_ready", wr_ready, 0);
        check("abort_link_rdy", link_rdy, 0);
        check("abort_busy",     busy,     0);
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("disabled_sr", oddr_sr, 1);
        @(negedge clk);
        en = 1'b1;
        bringup_check("reenable");
        sb_en = 1'b1;

        // Asynchronous reset in the middle of a burst
        sb_en    = 1'b0;
        wr_valid = 1'b1;
        wr_d1    = 8'hA5;
        wr_d2    = 8'h5A;
        guard = 0;
        while (!wr_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("rstmid_burst_started", wr_ready, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_reset");
        wr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bringup_check("rebringup");
        sb_en = 1'b1;

        do_burst('1, 1'b0, 1'b0, s1);
        repeat (PRE + POST + 8) @(negedge clk);
        check("scoreboard_drain", exp_len.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oddr_burst_ctrl.md
ODDR_BURST_CTRL -- requirements
Module: oddr_burst_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: data lanes, one ODDRE1 per lane.
REQ-002 SHALL have parameter BURST_LEN, default 4: clock cycles per burst, two beats per cycle.
REQ-003 SHALL have parameter SR_HOLD, default 4: cycles oddr_sr is held high after reset or enable, range 1..15.
REQ-004 SHALL have parameters PRE and POST, default 1 each: tristate-off cycles before and after the data.
REQ-005 SHALL have port clk  in  1  clock, rising edge, same clock as the ODDRE1 C input.
REQ-006 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have port en  in  1  link enable; low forces the ODDRs into reset.
REQ-008 SHALL have ports wr_valid in 1, wr_ready out 1, wr_d1 in DW, wr_d2 in DW: write stream; wr_d1 is the rising-edge half, wr_d2 the falling-edge half.
REQ-009 SHALL have ports oddr_sr out 1, oddr_d1 out DW, oddr_d2 out DW: drive ODDRE1 SR, D1 and D2.
REQ-010 SHALL have port oddr_tri  out  1  output-buffer tristate, 1 = high-Z.
REQ-011 SHALL have ports link_rdy out 1, busy out 1, underrun out 1 (one-cycle pulse).

Function
REQ-012 SHALL use FSM states HOLD, SETTLE, IDLE, PRE, BURST and POST.
REQ-013 SHALL, in HOLD, assert oddr_sr for SR_HOLD cycles while en=1, then go to SETTLE.
REQ-014 SHALL, in SETTLE, deassert oddr_sr for exactly 3 cycles, covering the ODDRE1 internal 3-stage SR release, then go to IDLE.
REQ-015 SHALL, in IDLE, set link_rdy=1 and wr_ready=0; wr_valid=1 moves the FSM to PRE, or straight to BURST when PRE=0.
REQ-016 SHALL, in PRE, stay PRE cycles with data 0 and tristate released.
REQ-017 SHALL, in BURST, hold wr_ready=1 for exactly BURST_LEN cycles; the beat counter advances every cycle regardless of wr_valid.
REQ-018 SHALL, on a BURST cycle with wr_valid=0, drive zero data and pulse underrun for 1 cycle; the burst is not extended.
REQ-019 SHALL, in POST, stay POST cycles with data 0 and tristate released, then go to IDLE.
REQ-020 SHALL register all oddr_* outputs; they reflect the previous cycle's state and accepted data (latency 1 from handshake to oddr_d1/oddr_d2).
REQ-021 SHALL register oddr_tri from the state: 0 for the cycle after PRE, BURST and POST cycles, 1 otherwise.
REQ-022 SHALL set busy=1 in PRE, BURST and POST, and 0 otherwise.
REQ-023 SHALL, when en=0 in any state, go to HOLD on the next edge, abort any burst and set oddr_tri=1, wr_ready=0 and link_rdy=0; the SR_HOLD count restarts when en returns high.
REQ-024 SHALL keep oddr_d1/oddr_d2 at 0 whenever the FSM is not in BURST.

Reset
REQ-025 SHALL, on rst=1, immediately set state HOLD, counters 0, oddr_sr=1, oddr_tri=1, oddr_d*=0, wr_ready=0, link_rdy=0, busy=0 and underrun=0.
REQ-026 SHALL start the SR_HOLD count on the first rising edge after rst falls with en=1.

Configuration
REQ-027 SHALL honour macro ODDR_BURST_CTRL_B2B_EN: when defined, wr_valid=1 in the last POST cycle moves the FSM directly to BURST (PRE and IDLE skipped, oddr_tri held 0); when undefined, POST always returns to IDLE.

Verification
REQ-028 SHALL be tested with: rst pulse, en=1, SR_HOLD=4 -> oddr_sr high 4 cycles after release, low 3 cycles, then link_rdy=1.
REQ-029 SHALL be tested with: wr_valid held high, data 0x11/0x22..0x77/0x88 -> oddr_tri low for 6 cycles, oddr_d1/d2 pairs in order 1 cycle after accept.
REQ-030 SHALL be tested with: wr_valid dropped on beat 2 of 4 -> underrun pulse, oddr_d*=0 that cycle, burst still ends after 4 BURST cycles.
REQ-031 SHALL be tested with: en=0 mid-BURST -> next cycle oddr_sr=1, oddr_tri=1, wr_ready=0; re-enable repeats HOLD(4) and SETTLE(3).
REQ-032 SHALL be tested with: two requests back-to-back -> with ODDR_BURST_CTRL_B2B_EN no IDLE/PRE gap and oddr_tri stays 0; without it one IDLE plus PRE cycle between bursts.
REQ-033 SHALL be tested with: rst asserted mid-burst -> all outputs take reset values without waiting for a clock edge.
